apbfifo_sync: RTL and testbench

Parametrised single-clock FIFO for the APB/I2C register path. Generalises the fixed 8x8 FIFO to configurable width and depth, and adds:
- runtime almost-full/almost-empty thresholds
- an occupancy count
- sticky overflow/underflow error flags
- a synchronous flush

It sits between the APB register slave and the I2C byte engine, one instance per direction (TX and RX).

---
 rtl/apbfifo_sync_if.sv | 34 +++
 rtl/apbfifo_sync.sv | 113 +++++++++++
 tb/tb_apbfifo_sync.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/apbfifo_sync_if.sv
// Bus bundle for apbfifo_sync: request/data/threshold inputs and status/error outputs.
// The master modport drives requests; the slave modport is the FIFO itself.
interface apbfifo_sync_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  flush;
    logic                  w_enable;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  r_enable;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CNT_W-1:0]      af_thresh;
    logic [CNT_W-1:0]      ae_thresh;
    logic [CNT_W-1:0]      count;
    logic                  overflow;
    logic                  underflow;
    logic                  clear_err;

    modport master (
        output flush, w_enable, w_data, r_enable, af_thresh, ae_thresh, clear_err,
        input  r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );

    modport slave (
        input  flush, w_enable, w_data, r_enable, af_thresh, ae_thresh, clear_err,
        output r_data, full, empty, almost_full, almost_empty, count, overflow, underflow
    );
endinterface

// File: rtl/apbfifo_sync.sv
// Parametrised single-clock FIFO with occupancy count, runtime almost-full/empty
// thresholds, sticky overflow/underflow flags and synchronous flush.
module apbfifo_sync #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic           clk,
    input  logic           rst,
    apbfifo_sync_if.slave  fifo_if
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    localparam logic [PTR_W-1:0]      PTR_ONE  = PTR_W'(1);
    localparam logic [PTR_W-1:0]      PTR_ZERO = PTR_W'(0);
    localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]      CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(DEPTH);
    localparam logic [DATA_WIDTH-1:0] DATA_ZERO = DATA_WIDTH'(0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic full_s, empty_s, wr_acc_s, rd_acc_s, ovf_evt_s, udf_evt_s, mem_we_s;

    assign full_s  = (count_q == CNT_FULL);
    assign empty_s = (count_q == CNT_ZERO);

    // A write into a full FIFO still lands when the same edge pops the oldest entry.
    assign rd_acc_s  = fifo_if.r_enable & ~empty_s;
    assign wr_acc_s  = fifo_if.w_enable & (~full_s | fifo_if.r_enable);
    assign ovf_evt_s = fifo_if.w_enable & full_s & ~fifo_if.r_enable;
    assign udf_evt_s = fifo_if.r_enable & empty_s;
    assign mem_we_s  = wr_acc_s & ~fifo_if.flush & ~rst;

    // Next-state for pointers, count, read data and sticky error flags.
    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        r_data_d    = r_data_q;
        overflow_d  = overflow_q & ~fifo_if.clear_err;
        underflow_d = underflow_q & ~fifo_if.clear_err;

        if (fifo_if.flush) begin
            wptr_d  = PTR_ZERO;
            rptr_d  = PTR_ZERO;
            count_d = CNT_ZERO;
        end else begin
            if (wr_acc_s) begin
                wptr_d = wptr_q + PTR_ONE;
            end else begin
                wptr_d = wptr_q;
            end
            if (rd_acc_s) begin
                rptr_d   = rptr_q + PTR_ONE;
                r_data_d = mem_q[rptr_q];
            end else begin
                rptr_d   = rptr_q;
                r_data_d = r_data_q;
            end
            case ({wr_acc_s, rd_acc_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // A new event outranks a simultaneous clear.
            overflow_d  = overflow_d | ovf_evt_s;
            underflow_d = underflow_d | udf_evt_s;
        end
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q      <= PTR_ZERO;
            rptr_q      <= PTR_ZERO;
            count_q     <= CNT_ZERO;
            r_data_q    <= DATA_ZERO;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            r_data_q    <= r_data_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[wptr_q] <= fifo_if.w_data;
        end
    end

    assign fifo_if.r_data       = r_data_q;
    assign fifo_if.count        = count_q;
    assign fifo_if.full         = full_s;
    assign fifo_if.empty        = empty_s;
    assign fifo_if.overflow     = overflow_q;
    assign fifo_if.underflow    = underflow_q;
    // Thresholds act combinationally so a new level shows in the same cycle.
    assign fifo_if.almost_full  = (fifo_if.af_thresh != CNT_ZERO) && (count_q >= fifo_if.af_thresh);
    assign fifo_if.almost_empty = (count_q <= fifo_if.ae_thresh);
endmodule

// File: tb/tb_apbfifo_sync.sv
// Directed self-checking bench for apbfifo_sync: a DEPTH=8 instance for fill/drain,
// error, flush and threshold cases, and a DEPTH=4 instance for pointer wrap streaming.
module tb_apbfifo_sync;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    apbfifo_sync_if #(.DATA_WIDTH(8), .DEPTH(8)) if8 ();
    apbfifo_sync_if #(.DATA_WIDTH(8), .DEPTH(4)) if4 ();

    apbfifo_sync #(.DATA_WIDTH(8), .DEPTH(8)) dut8 (.clk(clk), .rst(rst), .fifo_if(if8));
    apbfifo_sync #(.DATA_WIDTH(8), .DEPTH(4)) dut4 (.clk(clk), .rst(rst), .fifo_if(if4));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        if8.flush = 1'b0; if8.w_enable = 1'b0; if8.w_data = 8'h00; if8.r_enable = 1'b0;
        if8.af_thresh = 4'd7; if8.ae_thresh = 4'd1; if8.clear_err = 1'b0;
        if4.flush = 1'b0; if4.w_enable = 1'b0; if4.w_data = 8'h00; if4.r_enable = 1'b0;
        if4.af_thresh = 3'd3; if4.ae_thresh = 3'd1; if4.clear_err = 1'b0;
        step(); step();
        rst = 1'b0;
        step();

        // Reset state
        chk("rst_rdata", if8.r_data, 0);
        chk("rst_count", if8.count, 0);
        chk("rst_empty", if8.empty, 1);
        chk("rst_aempty", if8.almost_empty, 1);
        chk("rst_full", if8.full, 0);
        chk("rst_afull", if8.almost_full, 0);
        chk("rst_ovf", if8.overflow, 0);
        chk("rst_udf", if8.underflow, 0);

        // Fill 1..9
        if8.w_enable = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if8.w_data = 8'(i);
            step();
        end
        chk("fill6_count", if8.count, 6);
        chk("fill6_afull", if8.almost_full, 0);
        chk("fill6_aempty", if8.almost_empty, 0);
        if8.w_data = 8'd7; step();
        chk("fill7_count", if8.count, 7);
        chk("fill7_afull", if8.almost_full, 1);
        chk("fill7_full", if8.full, 0);
        if8.w_data = 8'd8; step();
        chk("fill8_full", if8.full, 1);
        chk("fill8_count", if8.count, 8);
        chk("fill8_ovf", if8.overflow, 0);
        if8.w_data = 8'd9; step();
        chk("fill9_ovf", if8.overflow, 1);
        chk("fill9_count", if8.count, 8);
        if8.w_enable = 1'b0;

        // Drain 1..8, then underflow
        if8.r_enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("drain_rdata", if8.r_data, i);
        end
        chk("drain_empty", if8.empty, 1);
        chk("drain_count", if8.count, 0);
        chk("drain_udf0", if8.underflow, 0);
        step();
        chk("udf_set", if8.underflow, 1);
        chk("udf_rdata_hold", if8.r_data, 8);
        if8.r_enable = 1'b0;
        if8.clear_err = 1'b1; step();
        if8.clear_err = 1'b0;
        chk("clr_ovf", if8.overflow, 0);
        chk("clr_udf", if8.underflow, 0);

        // Clear coinciding with a new underflow: set wins
        if8.r_enable = 1'b1; if8.clear_err = 1'b1; step();
        chk("setwins_udf", if8.underflow, 1);
        if8.r_enable = 1'b0; step();
        chk("clr_pending_udf", if8.underflow, 0);
        if8.clear_err = 1'b0;

        // Fill with 0x11..0x18, then write+read while full
        if8.w_enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            if8.w_data = 8'(8'h10 + i);
            step();
        end
        chk("full2_full", if8.full, 1);
        if8.r_enable = 1'b1; if8.w_data = 8'hA5; step();
        chk("wr_rd_full_count", if8.count, 8);
        chk("wr_rd_full_rdata", if8.r_data, 8'h11);
        chk("wr_rd_full_ovf", if8.overflow, 0);
        if8.w_enable = 1'b0;
        for (int i = 2; i <= 8; i++) begin
            step();
            chk("drain2_rdata", if8.r_data, 8'h10 + i);
        end
        step();
        chk("drain2_last_a5", if8.r_data, 8'hA5);
        chk("drain2_empty", if8.empty, 1);
        chk("drain2_udf", if8.underflow, 0);

        // Write+read while empty: write only, underflow set
        if8.w_enable = 1'b1; if8.w_data = 8'h3C; step();
        chk("wr_rd_empty_count", if8.count, 1);
        chk("wr_rd_empty_udf", if8.underflow, 1);
        chk("wr_rd_empty_rdata", if8.r_data, 8'hA5);
        if8.w_enable = 1'b0; step();
        chk("wr_rd_empty_read", if8.r_data, 8'h3C);
        chk("wr_rd_empty_cnt0", if8.count, 0);
        if8.r_enable = 1'b0; if8.clear_err = 1'b1; step();
        if8.clear_err = 1'b0;
        chk("clr2_udf", if8.underflow, 0);

        // Wrap streaming on DEPTH=4
        if4.w_enable = 1'b1; if4.w_data = 8'd1; step();
        chk("wrap_first_count", if4.count, 1);
        if4.r_enable = 1'b1;
        for (int k = 2; k <= 20; k++) begin
            if4.w_data = 8'(k);
            step();
            chk("wrap_rdata", if4.r_data, k - 1);
            chk("wrap_count", if4.count, 1);
        end
        if4.w_enable = 1'b0; step();
        if4.r_enable = 1'b0;
        chk("wrap_last", if4.r_data, 20);
        chk("wrap_empty", if4.empty, 1);
        chk("wrap_ovf", if4.overflow, 0);
        chk("wrap_udf", if4.underflow, 0);

        // Flush with pending write
        if8.w_enable = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            if8.w_data = 8'(8'h50 + i);
            step();
        end
        chk("pre_flush_count", if8.count, 5);
        if8.flush = 1'b1; if8.w_data = 8'h99; step();
        if8.flush = 1'b0; if8.w_enable = 1'b0;
        chk("flush_count", if8.count, 0);
        chk("flush_empty", if8.empty, 1);
        chk("flush_rdata", if8.r_data, 8'h3C);
        chk("flush_ovf", if8.overflow, 0);
        if8.flush = 1'b1; if8.r_enable = 1'b1; step();
        if8.flush = 1'b0; if8.r_enable = 1'b0;
        chk("flush_rd_udf", if8.underflow, 0);

        // Thresholds act combinationally
        if8.ae_thresh = 4'd0; #1;
        chk("ae0_empty", if8.almost_empty, 1);
        if8.w_enable = 1'b1; if8.w_data = 8'h61; step();
        if8.w_data = 8'h62; step();
        if8.w_enable = 1'b0;
        if8.ae_thresh = 4'd2; #1;
        chk("ae2_cnt2", if8.almost_empty, 1);
        if8.ae_thresh = 4'd1; #1;
        chk("ae1_cnt2", if8.almost_empty, 0);
        if8.af_thresh = 4'd0; #1;
        chk("af0_cnt2", if8.almost_full, 0);
        if8.af_thresh = 4'd2; #1;
        chk("af2_cnt2", if8.almost_full, 1);

        // Above-depth thresholds when full
        if8.w_enable = 1'b1;
        for (int i = 3; i <= 8; i++) begin
            if8.w_data = 8'(8'h60 + i);
            step();
        end
        if8.w_enable = 1'b0;
        chk("full3_count", if8.count, 8);
        if8.af_thresh = 4'd9; if8.ae_thresh = 4'd8; #1;
        chk("af9_full", if8.almost_full, 0);
        chk("ae8_full", if8.almost_empty, 1);
        if8.r_enable = 1'b1; step();
        if8.r_enable = 1'b0;
        chk("read_after_flush", if8.r_data, 8'h61);

        // Reset mid-stream
        if8.w_enable = 1'b1; if8.w_data = 8'h77; rst = 1'b1; step();
        rst = 1'b0; if8.w_enable = 1'b0;
        chk("rst2_count", if8.count, 0);
        chk("rst2_empty", if8.empty, 1);
        chk("rst2_rdata", if8.r_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
